// File: rtl/tws_pkg.sv
// tws_pkg: shared state encoding, default sizes and parity helper for the TWS burst slave.
package tws_pkg;
    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_DATA_W  = 16;
    localparam int DEF_BURST_W = 2;

    typedef enum logic [3:0] {
        IDLE, CMD, LEN, ADDR, WDATA, WPAR, RTA1, RREQ, RACK, RDATA, RPAR, RSTOP, RTA2
    } state_t;

    function automatic int cnt_w(input int a, input int b, input int c);
        int m;
        m = a > b ? a : b;
        m = m > c ? m : c;
        return m < 2 ? 1 : $clog2(m);
    endfunction

    function automatic logic even_par(input logic [63:0] d);
        return ^d;
    endfunction
endpackage

// File: rtl/tws_shreg.sv
// tws_shreg: LSB-first shift register with parallel load; new bits enter at the MSB.
module tws_shreg #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         shift,
    input  logic         load,
    input  logic         sin,
    input  logic [W-1:0] pin,
    output logic [W-1:0] q,
    output logic         sout
);
    always_ff @(posedge clk or posedge rst)
        if (rst) q <= '0;
        else if (load) q <= pin;
        else if (shift) q <= {sin, q[W-1:1]};

    assign sout = q[0];
endmodule

// File: rtl/tws_burst.sv
// tws_burst: single-wire burst register-access slave (write with parity check, read with parity generation).
module tws_burst
    import tws_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int BURST_W = DEF_BURST_W
) (
    input  logic              clk,
    input  logic              rst,
    inout  wire               SDA,
    input  logic [DATA_W-1:0] rd_data,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              par_err,
    output logic              busy,
    output logic              frame_done
);
    localparam int CNT_W = cnt_w(ADDR_W, DATA_W, BURST_W);
    localparam logic [CNT_W-1:0] LEN_LAST  = CNT_W'(BURST_W - 1);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

    state_t state, state_n;
    logic [CNT_W-1:0] bit_cnt;
    logic [BURST_W-1:0] word_cnt, len, nxt_word;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] rx_q, tx_q;
    logic cmd, last_word, par_ok, sda_oe, sda_o, tx_sout, rx_unused;

    assign last_word = word_cnt == len;
    assign par_ok    = even_par(64'(rx_q)) == SDA;
    assign nxt_word  = state == RPAR ? word_cnt + BURST_W'(1) : word_cnt;
    assign busy      = state != IDLE;

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_n;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = SDA ? IDLE : CMD;
            CMD:     state_n = LEN;
            LEN:     state_n = bit_cnt == LEN_LAST ? ADDR : LEN;
            ADDR:    state_n = bit_cnt == ADDR_LAST ? (cmd ? WDATA : RTA1) : ADDR;
            WDATA:   state_n = bit_cnt == DATA_LAST ? WPAR : WDATA;
            WPAR:    state_n = last_word ? IDLE : WDATA;
            RTA1:    state_n = RREQ;
            RREQ:    state_n = RACK;
            RACK:    state_n = RDATA;
            RDATA:   state_n = bit_cnt == DATA_LAST ? RPAR : RDATA;
            RPAR:    state_n = last_word ? RSTOP : RREQ;
            RSTOP:   state_n = RTA2;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt    <= '0;
            word_cnt   <= '0;
            len        <= '0;
            addr       <= '0;
            cmd        <= 1'b0;
            rd_en      <= 1'b0;
            rd_addr    <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            par_err    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            bit_cnt    <= (state_n != state || state == IDLE) ? '0 : bit_cnt + CNT_W'(1);
            word_cnt   <= state == IDLE ? '0 : (state == WPAR || state == RPAR) ? word_cnt + BURST_W'(1) : word_cnt;
            if (state == CMD) cmd <= SDA;
            if (state == LEN) len <= BURST_W'({SDA, len} >> 1);
            if (state == ADDR) addr <= ADDR_W'({SDA, addr} >> 1);
            rd_en      <= state_n == RREQ;
            if (state_n == RREQ) rd_addr <= addr + ADDR_W'(nxt_word);
            wr_en      <= state == WPAR && par_ok;
            par_err    <= state == WPAR && !par_ok;
            if (state == WPAR) begin
                wr_addr <= addr + ADDR_W'(word_cnt);
                wr_data <= rx_q;
            end
            frame_done <= (state == WPAR && last_word) || state == RTA2;
        end
    end

    tws_shreg #(.W(DATA_W)) u_rx (
        .clk(clk), .rst(rst), .shift(state == WDATA), .load(1'b0), .sin(SDA),
        .pin('0), .q(rx_q), .sout(rx_unused)
    );

    // Transmit rotates so the word is intact again for the parity bit after DATA_W shifts.
    tws_shreg #(.W(DATA_W)) u_tx (
        .clk(clk), .rst(rst), .shift(state == RDATA), .load(state == RACK), .sin(tx_sout),
        .pin(rd_data), .q(tx_q), .sout(tx_sout)
    );

    assign sda_oe = state inside {RREQ, RACK, RDATA, RPAR, RSTOP};
    assign sda_o  = state == RACK ? 1'b0 : state == RDATA ? tx_sout : state == RPAR ? even_par(64'(tx_q)) : 1'b1;
    assign SDA    = sda_oe ? sda_o : 1'bz;
endmodule
